// File: rtl/irem_bank_irq_map.sv
// Irem G-101 style PRG/CHR bank switching with an H3001 style CPU-cycle IRQ
// down-counter and full save-state access. All state updates on the m2 falling edge.
module irem_bank_irq_map #(
  parameter int PRG_W    = 6,
  parameter int CHR_W    = 8,
  parameter int CNT_W    = 16,
  parameter bit MIR_LOCK = 1'b0
) (
  input  logic             m2,
  input  logic             map_rst,
  input  logic [15:0]      cpu_addr,
  input  logic [7:0]       cpu_data,
  input  logic             cpu_rw,
  input  logic [13:0]      ppu_addr,
  input  logic             mir_1,
  input  logic             sst_act,
  input  logic             sst_we_reg,
  input  logic [7:0]       sst_addr,
  input  logic [7:0]       sst_dato,
  input  logic [7:0]       map_idx,
  output logic [PRG_W-1:0] prg_bank,
  output logic [CHR_W-1:0] chr_bank,
  output logic             ciram_a10,
  output logic             irq,
  output logic [7:0]       sst_di
);

  localparam int HI_W = CNT_W - 8;
  localparam logic [PRG_W-1:0] PRG_ONES = '1;
  localparam logic [PRG_W-1:0] PRG_RST  = PRG_ONES - PRG_W'(1);

  logic [PRG_W-1:0] prg0_q, prg0_d, prg1_q, prg1_d, prg2_q, prg2_d;
  logic [CHR_W-1:0] chr_q [8];
  logic [CHR_W-1:0] chr_d [8];
  logic [1:0]       mode_q, mode_d;
  logic             irq_en_q, irq_en_d;
  logic             irq_q, irq_d;
  logic [CNT_W-1:0] latch_q, latch_d, cnt_q, cnt_d;
  logic             unused_bits;

  assign unused_bits = ^{cpu_addr[11:3], ppu_addr[13], ppu_addr[9:0]};

  always_comb begin
    prg0_d   = prg0_q;
    prg1_d   = prg1_q;
    prg2_d   = prg2_q;
    chr_d    = chr_q;
    mode_d   = mode_q;
    irq_en_d = irq_en_q;
    irq_d    = irq_q;
    latch_d  = latch_q;
    cnt_d    = cnt_q;
    if (sst_act) begin
      // Save-state access freezes the counter; only explicit writes change state.
      if (sst_we_reg) begin
        if (sst_addr < 8'd8) begin
          chr_d[sst_addr[2:0]] = CHR_W'(sst_dato);
        end else begin
          case (sst_addr)
            8'd8:  prg0_d = PRG_W'(sst_dato);
            8'd9:  prg1_d = PRG_W'(sst_dato);
            8'd10: prg2_d = PRG_W'(sst_dato);
            8'd11: begin
              irq_d    = sst_dato[3];
              irq_en_d = sst_dato[2];
              mode_d   = sst_dato[1:0];
            end
            8'd12: latch_d[7:0]       = sst_dato;
            8'd13: latch_d[CNT_W-1:8] = HI_W'(sst_dato);
            8'd14: cnt_d[7:0]         = sst_dato;
            8'd15: cnt_d[CNT_W-1:8]   = HI_W'(sst_dato);
            default: ;
          endcase
        end
      end
    end else if (map_rst) begin
      prg0_d   = PRG_RST;
      prg1_d   = PRG_ONES;
      prg2_d   = PRG_RST;
      for (int i = 0; i < 8; i++) chr_d[i] = '0;
      mode_d   = 2'd0;
      irq_en_d = 1'b0;
      irq_d    = 1'b0;
      latch_d  = '0;
      cnt_d    = '0;
    end else begin
      if (irq_en_q && (cnt_q != '0)) begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) irq_d = 1'b1;
      end
      // CPU writes come after the count so a reload on the terminal edge wins.
      if (!cpu_rw) begin
        case (cpu_addr[15:12])
          4'h8: begin
            if (mode_q[1]) prg2_d = PRG_W'(cpu_data);
            else           prg0_d = PRG_W'(cpu_data);
          end
          4'h9: if (!MIR_LOCK) mode_d = cpu_data[1:0];
          4'hA: prg1_d = PRG_W'(cpu_data);
          4'hB: chr_d[cpu_addr[2:0]] = CHR_W'(cpu_data);
          4'hC: begin
            case (cpu_addr[2:0])
              3'd0: begin
                irq_en_d = cpu_data[7];
                irq_d    = 1'b0;
              end
              3'd1: begin
                cnt_d = latch_q;
                irq_d = 1'b0;
              end
              3'd2: latch_d[CNT_W-1:8] = HI_W'(cpu_data);
              3'd3: latch_d[7:0]       = cpu_data;
              default: ;
            endcase
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(negedge m2) begin
    prg0_q   <= prg0_d;
    prg1_q   <= prg1_d;
    prg2_q   <= prg2_d;
    chr_q    <= chr_d;
    mode_q   <= mode_d;
    irq_en_q <= irq_en_d;
    irq_q    <= irq_d;
    latch_q  <= latch_d;
    cnt_q    <= cnt_d;
  end

  always_comb begin
    case (cpu_addr[14:13])
      2'd0:    prg_bank = prg0_q;
      2'd1:    prg_bank = prg1_q;
      2'd2:    prg_bank = prg2_q;
      default: prg_bank = PRG_ONES;
    endcase
  end

  assign chr_bank  = chr_q[ppu_addr[12:10]];
  assign ciram_a10 = (mir_1 || MIR_LOCK) ? 1'b1 : (mode_q[0] ? ppu_addr[11] : ppu_addr[10]);
  assign irq       = irq_q;

  always_comb begin
    sst_di = 8'hFF;
    case (sst_addr)
      8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7:
             sst_di = 8'(chr_q[sst_addr[2:0]]);
      8'd8:  sst_di = 8'(prg0_q);
      8'd9:  sst_di = 8'(prg1_q);
      8'd10: sst_di = 8'(prg2_q);
      8'd11: sst_di = {4'd0, irq_q, irq_en_q, mode_q};
      8'd12: sst_di = latch_q[7:0];
      8'd13: sst_di = 8'(latch_q[CNT_W-1:8]);
      8'd14: sst_di = cnt_q[7:0];
      8'd15: sst_di = 8'(cnt_q[CNT_W-1:8]);
      8'd127: sst_di = map_idx;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_irem_bank_irq_map.sv
// Bench for irem_bank_irq_map: directed vectors, a register-level model checked
// every cycle, and literal expectations at the interesting points.
module tb_irem_bank_irq_map;
  localparam int PRG_W = 6;
  localparam int CHR_W = 8;
  localparam int CNT_W = 16;
  localparam int PRG_M = (1 << PRG_W) - 1;
  localparam int HI_M  = (1 << (CNT_W - 8)) - 1;

  // clock / reset
  logic m2;
  initial m2 = 1'b0;
  always #5 m2 = ~m2;

  logic        map_rst, cpu_rw, mir_1, sst_act, sst_we_reg;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data, sst_addr, sst_dato, map_idx;
  logic [13:0] ppu_addr;
  logic [PRG_W-1:0] prg_bank, prg_bank_l;
  logic [CHR_W-1:0] chr_bank, chr_bank_l;
  logic        ciram_a10, ciram_a10_l, irq, irq_l;
  logic [7:0]  sst_di, sst_di_l;

  irem_bank_irq_map #(.PRG_W(PRG_W), .CHR_W(CHR_W), .CNT_W(CNT_W), .MIR_LOCK(1'b0)) dut (
    .m2(m2), .map_rst(map_rst), .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_rw(cpu_rw),
    .ppu_addr(ppu_addr), .mir_1(mir_1), .sst_act(sst_act), .sst_we_reg(sst_we_reg),
    .sst_addr(sst_addr), .sst_dato(sst_dato), .map_idx(map_idx), .prg_bank(prg_bank),
    .chr_bank(chr_bank), .ciram_a10(ciram_a10), .irq(irq), .sst_di(sst_di));

  irem_bank_irq_map #(.PRG_W(PRG_W), .CHR_W(CHR_W), .CNT_W(CNT_W), .MIR_LOCK(1'b1)) dut_l (
    .m2(m2), .map_rst(map_rst), .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_rw(cpu_rw),
    .ppu_addr(ppu_addr), .mir_1(mir_1), .sst_act(sst_act), .sst_we_reg(sst_we_reg),
    .sst_addr(sst_addr), .sst_dato(sst_dato), .map_idx(map_idx), .prg_bank(prg_bank_l),
    .chr_bank(chr_bank_l), .ciram_a10(ciram_a10_l), .irq(irq_l), .sst_di(sst_di_l));

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // behavioural model of the unlocked instance
  int m_prg[3];
  int m_chr[8];
  int m_mode, m_en, m_latch, m_cnt, m_irq;
  bit m_valid = 1'b0;

  task automatic m_reset();
    m_prg[0] = PRG_M - 1;
    m_prg[1] = PRG_M;
    m_prg[2] = PRG_M - 1;
    foreach (m_chr[i]) m_chr[i] = 0;
    m_mode = 0; m_en = 0; m_latch = 0; m_cnt = 0; m_irq = 0;
  endtask

  task automatic m_cpu_write(input int a, input int d);
    int sel;
    int low;
    sel = (a >> 12) & 15;
    low = a & 7;
    case (sel)
      8:  if (m_mode >= 2) m_prg[2] = d & PRG_M; else m_prg[0] = d & PRG_M;
      9:  m_mode = d & 3;
      10: m_prg[1] = d & PRG_M;
      11: m_chr[low] = d & 255;
      12: begin
        case (low)
          0: begin m_en = (d >> 7) & 1; m_irq = 0; end
          1: begin m_cnt = m_latch; m_irq = 0; end
          2: m_latch = (m_latch & 255) | ((d & HI_M) << 8);
          3: m_latch = (m_latch & ~255) | d;
          default: ;
        endcase
      end
      default: ;
    endcase
  endtask

  task automatic m_sst_write(input int idx, input int d);
    if (idx < 8) m_chr[idx] = d;
    else if (idx <= 10) m_prg[idx - 8] = d & PRG_M;
    else if (idx == 11) begin
      m_mode = d & 3; m_en = (d >> 2) & 1; m_irq = (d >> 3) & 1;
    end
    else if (idx == 12) m_latch = (m_latch & ~255) | d;
    else if (idx == 13) m_latch = (m_latch & 255) | ((d & HI_M) << 8);
    else if (idx == 14) m_cnt = (m_cnt & ~255) | d;
    else if (idx == 15) m_cnt = (m_cnt & 255) | ((d & HI_M) << 8);
  endtask

  always @(negedge m2) begin
    if (sst_act) begin
      if (sst_we_reg) m_sst_write(int'(sst_addr), int'(sst_dato));
    end else if (map_rst) begin
      m_reset();
      m_valid = 1'b1;
    end else begin
      if (m_en != 0 && m_cnt > 0) begin
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) m_irq = 1;
      end
      if (!cpu_rw) m_cpu_write(int'(cpu_addr), int'(cpu_data));
    end
  end

  function automatic int exp_prg();
    int sel;
    sel = int'(cpu_addr[14:13]);
    return (sel == 3) ? PRG_M : m_prg[sel];
  endfunction

  function automatic int exp_a10();
    if (mir_1) return 1;
    return (m_mode & 1) ? int'(ppu_addr[11]) : int'(ppu_addr[10]);
  endfunction

  function automatic int exp_sst(input int idx);
    if (idx < 8) return m_chr[idx];
    if (idx <= 10) return m_prg[idx - 8];
    if (idx == 11) return m_irq * 8 + m_en * 4 + m_mode;
    if (idx == 12) return m_latch & 255;
    if (idx == 13) return m_latch >> 8;
    if (idx == 14) return m_cnt & 255;
    if (idx == 15) return m_cnt >> 8;
    if (idx == 127) return int'(map_idx);
    return 255;
  endfunction

  // per-cycle compare, well clear of the falling edge
  always @(posedge m2) begin
    #3;
    if (m_valid) begin
      chk("cyc_prg", 32'(prg_bank), exp_prg());
      chk("cyc_chr", 32'(chr_bank), m_chr[ppu_addr[12:10]]);
      chk("cyc_a10", 32'(ciram_a10), exp_a10());
      chk("cyc_irq", 32'(irq), m_irq);
      chk("cyc_sst", 32'(sst_di), exp_sst(int'(sst_addr)));
      chk("cyc_lock_a10", 32'(ciram_a10_l), 1);
      chk("cyc_lock_irq", 32'(irq_l), m_irq);
      chk("cyc_lock_chr", 32'(chr_bank_l), m_chr[ppu_addr[12:10]]);
      if (sst_addr < 8'd8 || sst_addr > 8'd11)
        chk("cyc_lock_sst", 32'(sst_di_l), exp_sst(int'(sst_addr)));
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge m2);
    #1;
  endtask

  task automatic cpu_wr(input logic [15:0] a, input logic [7:0] d);
    cpu_addr = a; cpu_data = d; cpu_rw = 1'b0;
    tick(1);
    cpu_rw = 1'b1;
  endtask

  task automatic sst_wr(input logic [7:0] idx, input logic [7:0] d);
    sst_act = 1'b1; sst_we_reg = 1'b1; sst_addr = idx; sst_dato = d;
    tick(1);
    sst_we_reg = 1'b0;
  endtask

  task automatic sst_peek(input logic [7:0] idx, input string name, input logic [7:0] exp);
    sst_act = 1'b1; sst_addr = idx;
    #1;
    chk(name, 32'(sst_di), 32'(exp));
    tick(1);
    sst_act = 1'b0;
  endtask

  task automatic probe_prg(input logic [15:0] a, input string name, input int exp);
    cpu_addr = a;
    #1;
    chk(name, 32'(prg_bank), exp);
    tick(1);
  endtask

  task automatic probe_a10(input logic [13:0] pa, input string name, input int exp, input int exp_l);
    ppu_addr = pa;
    #1;
    chk(name, 32'(ciram_a10), exp);
    chk({name, "_lock"}, 32'(ciram_a10_l), exp_l);
    tick(1);
  endtask

  initial begin
    map_rst = 1'b1; cpu_rw = 1'b1; cpu_addr = 16'h0; cpu_data = 8'h0;
    ppu_addr = 14'h0; mir_1 = 1'b0; sst_act = 1'b0; sst_we_reg = 1'b0;
    sst_addr = 8'h0; sst_dato = 8'h0; map_idx = 8'd32;
    tick(3);
    map_rst = 1'b0;

    // reset state
    probe_prg(16'h8000, "rst_prg_8000", 62);
    probe_prg(16'hA000, "rst_prg_A000", 63);
    probe_prg(16'hC000, "rst_prg_C000", 62);
    probe_prg(16'hE000, "rst_prg_E000", 63);
    chk("rst_irq", 32'(irq), 0);
    sst_peek(8'd11, "rst_ctl", 8'h00);
    sst_peek(8'd14, "rst_cnt", 8'h00);

    // PRG mode switch
    cpu_wr(16'h9000, 8'h02);
    cpu_wr(16'h8000, 8'h05);
    cpu_wr(16'hA000, 8'h47);
    probe_prg(16'hC000, "prg2_at_C000", 5);
    probe_prg(16'h8000, "prg0_kept", 62);
    chk("lock_prg0", 32'(prg_bank_l), 5);
    probe_prg(16'hA000, "prg1_trunc", 7);
    probe_prg(16'hE000, "prg_fixed", 63);

    // CHR and mirroring
    cpu_wr(16'hB003, 8'hA7);
    ppu_addr = 14'h0C00;
    #1;
    chk("chr3", 32'(chr_bank), 32'hA7);
    tick(1);
    cpu_wr(16'h9000, 8'h00);
    probe_a10(14'h2400, "a10_h_2400", 1, 1);
    probe_a10(14'h2800, "a10_h_2800", 0, 1);
    cpu_wr(16'h9000, 8'h01);
    probe_a10(14'h2400, "a10_v_2400", 0, 1);
    probe_a10(14'h2800, "a10_v_2800", 1, 1);
    mir_1 = 1'b1;
    probe_a10(14'h2400, "a10_mir1", 1, 1);
    mir_1 = 1'b0;

    // IRQ fires on the 3rd edge after enable
    cpu_wr(16'hC002, 8'h00);
    cpu_wr(16'hC003, 8'h03);
    cpu_wr(16'hC001, 8'h00);
    cpu_wr(16'hC000, 8'h80);
    tick(2);
    chk("irq_before", 32'(irq), 0);
    tick(1);
    chk("irq_fire", 32'(irq), 1);
    sst_peek(8'd14, "cnt_zero", 8'h00);
    tick(3);
    chk("irq_held", 32'(irq), 1);
    sst_peek(8'd14, "cnt_no_wrap", 8'h00);
    cpu_wr(16'hC000, 8'h80);
    chk("irq_ack", 32'(irq), 0);
    tick(3);
    chk("irq_no_restart", 32'(irq), 0);
    sst_peek(8'd14, "cnt_still_zero", 8'h00);

    // reload on the terminal edge wins
    cpu_wr(16'hC001, 8'h00);
    tick(2);
    cpu_wr(16'hC001, 8'h00);
    chk("reload_term_irq", 32'(irq), 0);
    sst_peek(8'd14, "reload_term_cnt", 8'h03);

    // disable freezes at 5
    cpu_wr(16'hC003, 8'h08);
    cpu_wr(16'hC001, 8'h00);
    tick(2);
    cpu_wr(16'hC000, 8'h00);
    tick(10);
    sst_peek(8'd14, "frozen_lo", 8'h05);
    sst_peek(8'd15, "frozen_hi", 8'h00);
    chk("frozen_irq", 32'(irq), 0);

    // save-state write/read with a concurrent cpu write that must be ignored
    cpu_addr = 16'hA000; cpu_data = 8'h11; cpu_rw = 1'b0;
    for (int i = 0; i < 16; i++) begin
      logic [7:0] p;
      logic [7:0] mask;
      p = 8'(i * 37 + 165);
      mask = (i >= 8 && i <= 10) ? 8'h3F : ((i == 11) ? 8'h0F : 8'hFF);
      exp_q.push_back(p & mask);
      sst_wr(8'(i), p);
    end
    for (int i = 0; i < 16; i++) begin
      sst_addr = 8'(i);
      #1;
      chk("sst_rd", 32'(sst_di), 32'(exp_q.pop_front()));
      tick(1);
    end
    sst_addr = 8'd127;
    #1;
    chk("sst_map_idx", 32'(sst_di), 32'd32);
    tick(1);
    sst_addr = 8'd16;
    #1;
    chk("sst_idx16", 32'(sst_di), 32'hFF);
    tick(1);
    cpu_rw = 1'b1;
    sst_act = 1'b0;
    tick(1);

    // reset mid-count with irq pending
    sst_wr(8'd11, 8'h0C);
    sst_wr(8'd14, 8'h00);
    sst_wr(8'd15, 8'h01);
    sst_act = 1'b0;
    tick(3);
    chk("pre_rst_irq", 32'(irq), 1);
    map_rst = 1'b1;
    tick(1);
    map_rst = 1'b0;
    chk("post_rst_irq", 32'(irq), 0);
    sst_peek(8'd14, "post_rst_cnt_lo", 8'h00);
    sst_peek(8'd15, "post_rst_cnt_hi", 8'h00);
    probe_prg(16'h8000, "post_rst_prg0", 62);
    probe_prg(16'hA000, "post_rst_prg1", 63);
    probe_prg(16'hC000, "post_rst_prg2", 62);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
